// File: rtl/debug_uart_tx.sv
// Debug frame UART transmitter: snapshots seven debug bytes and sends
// SYNC, the bytes and their mod-256 sum as 8N1 serial, LSB first.
module debug_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       trigger,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  state_t          state_q;
  logic [15:0]     cnt_q;
  logic [3:0]      byte_q;
  logic [2:0]      bit_q;
  logic [6:0][7:0] snap_q;
  logic [7:0]      chk_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;

  logic [7:0]      sum_d;
  logic [7:0]      cur_byte;
  logic [2:0]      nbit_d;

  // Checksum of the live ports, latched together with the snapshot
  always_comb begin
    sum_d = debug_port1 + debug_port2 + debug_port3 + debug_port4
          + debug_port5 + debug_port6 + debug_port7;
  end

  // Byte currently being shifted out, selected by the byte index
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_q)
      4'd1:    cur_byte = snap_q[0];
      4'd2:    cur_byte = snap_q[1];
      4'd3:    cur_byte = snap_q[2];
      4'd4:    cur_byte = snap_q[3];
      4'd5:    cur_byte = snap_q[4];
      4'd6:    cur_byte = snap_q[5];
      4'd7:    cur_byte = snap_q[6];
      4'd8:    cur_byte = chk_q;
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  assign nbit_d = bit_q + 3'd1;

  // Frame sequencer; tx/busy/done are registered so the line never glitches
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      snap_q  <= '0;
      chk_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (trigger) begin
            snap_q  <= {debug_port7, debug_port6, debug_port5,
                        debug_port4, debug_port3, debug_port2,
                        debug_port1};
            chk_q   <= sum_d;
            state_q <= START;
            byte_q  <= '0;
            bit_q   <= '0;
            cnt_q   <= RELOAD;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            cnt_q   <= RELOAD;
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= cur_byte[0];
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= RELOAD;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= nbit_d;
              tx_q  <= cur_byte[nbit_d];
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            bit_q <= '0;
            if (byte_q == 4'd8) begin
              state_q <= IDLE;
              byte_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              tx_q    <= 1'b1;
            end else begin
              state_q <= START;
              byte_q  <= byte_q + 4'd1;
              cnt_q   <= RELOAD;
              tx_q    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: frame-level model, per-cycle compare,
// UART decoder and directed scenarios with literal expectations.
module tb_debug_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 90 * C;

  logic       clk     = 1'b0;
  logic       nreset  = 1'b1;
  logic       trigger = 1'b0;
  logic [7:0] dp [7];
  logic       tx;
  logic       busy;
  logic       done;

  debug_uart_tx #(
    .CLKS_PER_BIT(C),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .trigger    (trigger),
    .debug_port1(dp[0]),
    .debug_port2(dp[1]),
    .debug_port3(dp[2]),
    .debug_port4(dp[3]),
    .debug_port5(dp[4]),
    .debug_port6(dp[5]),
    .debug_port7(dp[6]),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame model: t counts edges since acceptance; line level from bit slot
  int         m_t = -1;
  logic [7:0] m_b [9];
  logic       e_tx   = 1'b1;
  logic       e_busy = 1'b0;
  logic       e_done = 1'b0;

  function automatic logic mbit(input int t);
    int n;
    int p;
    n = t / C;
    p = n % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return m_b[n / 10][p - 1];
  endfunction

  initial forever begin
    @(posedge clk or negedge nreset);
    if (!nreset) begin
      m_t    = -1;
      e_tx   = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      if (m_t >= 0) begin
        m_t++;
        if (m_t == FRAME) begin
          m_t    = -1;
          e_done = 1'b1;
        end
      end else if (trigger) begin
        m_t     = 0;
        m_b[0]  = 8'hA5;
        m_b[8]  = 8'h00;
        for (int i = 1; i < 8; i++) begin
          m_b[i] = dp[i - 1];
          m_b[8] = m_b[8] + dp[i - 1];
        end
      end
      e_busy = (m_t >= 0);
      e_tx   = (m_t >= 0) ? mbit(m_t) : 1'b1;
    end
  end

  int   cyc      = 0;
  int   busy_cyc = 0;
  int   done_cnt = 0;
  int   starts[$];
  logic pb       = 1'b0;

  initial forever @(posedge clk) cyc++;

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("tx", {31'd0, tx}, {31'd0, e_tx});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (busy && !pb) starts.push_back(cyc);
    pb = busy;
  end

  // UART receiver sampling mid-bit
  logic [7:0] rxq[$];

  initial begin : decoder
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (busy && tx == 1'b0) begin
        repeat (C / 2) @(negedge clk);
        chk("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx;
        end
        repeat (C) @(negedge clk);
        chk("stop_bit", {31'd0, tx}, 32'd1);
        rxq.push_back(b);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    chk("done_timeout", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic check_frame(input string nm, input logic [7:0] e[9],
                             input int off);
    for (int i = 0; i < 9; i++) begin
      if (off + i < rxq.size())
        chk($sformatf("%s_byte%0d", nm, i), {24'd0, rxq[off + i]},
            {24'd0, e[i]});
      else
        chk($sformatf("%s_missing%0d", nm, i), 32'd0, 32'd1);
    end
  endtask

  task automatic set_ports(input logic [7:0] base, input logic [7:0] inc);
    for (int i = 0; i < 7; i++) dp[i] = base + inc * 8'(i);
  endtask

  initial begin : stim
    logic [7:0] e1 [9];
    logic [7:0] e2 [9];
    logic [7:0] e3 [9];
    logic [7:0] e5 [9];
    e1 = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h1C};
    e2 = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9};
    e3 = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'hC0};
    e5 = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'hDC};
    set_ports(8'h00, 8'h00);
    #1 nreset = 1'b0;
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    step(3);
    nreset = 1'b1;
    step(2);

    // Basic frame
    set_ports(8'h01, 8'h01);
    rxq.delete();
    busy_cyc = 0;
    pulse();
    chk("model_sum_1c", {24'd0, m_b[8]}, 32'h1C);
    wait_done(1, FRAME + 20);
    chk("t1_len", rxq.size(), 9);
    check_frame("t1", e1, 0);
    chk("t1_busy_cycles", busy_cyc, 360);
    chk("t1_done_count", done_cnt, 1);

    // All ones, checksum wraps
    set_ports(8'hFF, 8'h00);
    rxq.delete();
    pulse();
    chk("model_sum_f9", {24'd0, m_b[8]}, 32'hF9);
    wait_done(2, FRAME + 20);
    chk("t2_len", rxq.size(), 9);
    check_frame("t2", e2, 0);

    // Ports change after capture
    set_ports(8'h10, 8'h10);
    rxq.delete();
    pulse();
    step(4);
    set_ports(8'h00, 8'h00);
    wait_done(3, FRAME + 20);
    chk("t3_len", rxq.size(), 9);
    check_frame("t3", e3, 0);

    // Triggers during a frame are ignored
    set_ports(8'h01, 8'h01);
    rxq.delete();
    starts.delete();
    busy_cyc = 0;
    pulse();
    step(9);
    pulse();
    step(189);
    pulse();
    wait_done(4, FRAME + 20);
    step(10);
    chk("t4_starts", starts.size(), 1);
    chk("t4_busy_cycles", busy_cyc, 360);
    chk("t4_done_count", done_cnt, 4);
    chk("t4_len", rxq.size(), 9);
    check_frame("t4", e1, 0);

    // Held trigger: back-to-back frames with a one-cycle gap
    set_ports(8'h11, 8'h11);
    rxq.delete();
    starts.delete();
    trigger = 1'b1;
    for (int n = 0; n < 1000 && starts.size() < 2; n++) step(1);
    trigger = 1'b0;
    chk("t5_two_starts", starts.size(), 2);
    if (starts.size() >= 2)
      chk("t5_gap", starts[1] - starts[0], 361);
    wait_done(6, 2 * FRAME + 20);
    chk("t5_len", rxq.size(), 18);
    check_frame("t5a", e5, 0);
    check_frame("t5b", e5, 9);

    // Reset mid-frame aborts without done
    set_ports(8'h01, 8'h01);
    pulse();
    step(99);
    nreset = 1'b0;
    #1;
    chk("t6_rst_tx", {31'd0, tx}, 32'd1);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    step(2);
    nreset = 1'b1;
    step(FRAME);
    chk("t6_no_done", done_cnt, 6);
    rxq.delete();
    pulse();
    wait_done(7, FRAME + 20);
    chk("t6_len", rxq.size(), 9);
    check_frame("t6", e1, 0);

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
